// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
//   Time-multiplexed scan scheduler for a four-digit common-anode display.
//   A prescaler divides clk down to one slot per DIV cycles. Slots rotate
//   0,1,2,3. Each slot begins with BLANK dead cycles to suppress ghosting.
//   A 16-bit shadow register holds the displayed digits. It is reloaded
//   from digits_in only at a frame boundary, so a frame never mixes old
//   and new values.
//
// Parameters
//   DIV    clk cycles per digit slot (2..65535)
//   BLANK  dead-time cycles at the start of each slot (0..DIV-1)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   en           scan enable; while low the prescaler and slot index hold
//   digits_in    four nibbles, digit k = bits 4k+3..4k
//   upd_req      load request, held high until acknowledged
//   upd_ack      one-cycle acknowledge; shadow captures digits_in on that edge
//   digit_sel    current slot index
//   anode_n      active-low one-hot digit enable
//   nibble       shadow nibble for the current slot
//   frame_start  high in the last cycle of slot 3 (frame boundary)
//
// Optional feature
//   SCAN_LEADING_ZERO_BLANK_EN: when defined, slots 3..1 are blanked while
//   their shadow digit and every higher digit are zero. Slot 0 always shows.

module display_scan_scheduler #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [1:0]  digit_sel,
  output logic [3:0]  anode_n,
  output logic [3:0]  nibble,
  output logic        frame_start
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] count;
  logic [15:0] shadow;
  logic        tick;
  logic        in_dead;
  logic        lz_blank;

  assign tick = en && (count == LAST);

  // rst gating keeps the strobes low throughout reset, not only once the
  // asynchronous clear has propagated through count.
  assign frame_start = !rst && tick && (digit_sel == 2'd3);
  assign upd_ack     = frame_start && upd_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      digit_sel <= '0;
      shadow    <= '0;
    end else begin
      if (tick) begin
        count     <= '0;
        digit_sel <= digit_sel + 2'd1;
      end else if (en) begin
        count <= count + 16'd1;
      end
      if (upd_ack) begin
        shadow <= digits_in;
      end
    end
  end

  always_comb begin
    nibble = '0;
    case (digit_sel)
      2'd0: nibble = shadow[3:0];
      2'd1: nibble = shadow[7:4];
      2'd2: nibble = shadow[11:8];
      2'd3: nibble = shadow[15:12];
      default: nibble = '0;
    endcase
  end

  // With BLANK=0 there is no dead time at all. The comparison is elided
  // because count < 0 can never be true.
  generate
    if (BLANK == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      localparam logic [15:0] BLANK_C = 16'(BLANK);
      assign in_dead = (count < BLANK_C);
    end
  endgenerate

`ifdef SCAN_LEADING_ZERO_BLANK_EN
  // Each zN is true when digit N and all digits above it are zero.
  logic z3;
  logic z2;
  logic z1;

  assign z3 = (shadow[15:12] == 4'h0);
  assign z2 = z3 && (shadow[11:8] == 4'h0);
  assign z1 = z2 && (shadow[7:4]  == 4'h0);

  always_comb begin
    lz_blank = 1'b0;
    case (digit_sel)
      2'd3: lz_blank = z3;
      2'd2: lz_blank = z2;
      2'd1: lz_blank = z1;
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    anode_n = '1;
    if (!rst && en && !in_dead && !lz_blank) begin
      anode_n = ~(4'b0001 << digit_sel);
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic        upd_req;
  logic        upd_ack;
  logic [1:0]  digit_sel;
  logic [3:0]  anode_n;
  logic [3:0]  nibble;
  logic        frame_start;

  display_scan_scheduler #(.DIV(8), .BLANK(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits_in   (digits_in),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .digit_sel   (digit_sel),
    .anode_n     (anode_n),
    .nibble      (nibble),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // reference state, advanced once per clock edge
  int          m_cnt;
  logic [1:0]  m_sel;
  logic [15:0] m_sh;

  // scoreboard of words expected to be captured, in order
  logic [15:0] sbq[$];
  logic [15:0] cap;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [11:0] RESET_OUT = {1'b0, 1'b0, 2'd0, 4'hF, 4'h0};

  function automatic logic [11:0] dut_out();
    return {upd_ack, frame_start, digit_sel, anode_n, nibble};
  endfunction

  function automatic logic [11:0] exp_out();
    logic        tick;
    logic        fs;
    logic        ack;
    logic [3:0]  an;
    logic [15:0] sh;
    if (rst) return RESET_OUT;
    tick = en && (m_cnt == 7);
    fs   = tick && (m_sel == 2'd3);
    ack  = fs && upd_req;
    sh   = m_sh >> (4 * int'(m_sel));
    an   = 4'hF;
    if (en && m_cnt >= 2) begin
      an = 4'hF;
      an[m_sel] = 1'b0;
    end
`ifdef SCAN_LEADING_ZERO_BLANK_EN
    if (m_sel == 2'd3 && m_sh[15:12] == 4'h0) an = 4'hF;
    if (m_sel == 2'd2 && m_sh[15:8]  == 8'h0) an = 4'hF;
    if (m_sel == 2'd1 && m_sh[15:4]  == 12'h0) an = 4'hF;
`endif
    return {ack, fs, m_sel, an, sh[3:0]};
  endfunction

  // Advance one clock: observe ack before the edge, update the model,
  // return at 1 time unit after the rising edge.
  task automatic step();
    logic tick;
    logic ack;
    #2;
    tick = !rst && en && (m_cnt == 7);
    ack  = tick && (m_sel == 2'd3) && upd_req;
    if (upd_ack === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_ack actual=1 required=0 t=%0t", $time);
      end else begin
        cap = sbq.pop_front();
      end
    end
    if (rst) begin
      m_cnt = 0;
      m_sel = 2'd0;
      m_sh  = 16'h0;
    end else begin
      if (ack) m_sh = digits_in;
      if (tick) begin
        m_cnt = 0;
        m_sel = m_sel + 2'd1;
      end else if (en) begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int sel, input int cnt);
    int i;
    i = 0;
    while (!(m_sel == 2'(sel) && m_cnt == cnt) && i < 80) begin
      step();
      if (dut_out() !== exp_out()) begin
        n_miss++;
        $display("FAIL goto_track actual=%h required=%h t=%0t", dut_out(), exp_out(), $time);
      end
      n_vec++;
      i++;
    end
    if (i >= 80) begin
      n_vec++;
      n_miss++;
      $display("FAIL goto_timeout actual=sel%0d/cnt%0d required=sel%0d/cnt%0d", m_sel, m_cnt, sel, cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; upd_req = 1'b0; digits_in = 16'h0;
    m_cnt = 0; m_sel = 2'd0; m_sh = 16'h0;
    @(posedge clk); #1;
    if (dut_out() !== RESET_OUT) begin
      n_miss++;
      $display("FAIL reset_en0 actual=%h required=%h", dut_out(), RESET_OUT);
    end
    n_vec++;
    en = 1'b1;
    step(); step();
    if (dut_out() !== RESET_OUT) begin
      n_miss++;
      $display("FAIL reset_en1 actual=%h required=%h", dut_out(), RESET_OUT);
    end
    n_vec++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dut_out() !== exp_out()) begin
        n_miss++;
        $display("FAIL reset_release actual=%h required=%h", dut_out(), exp_out());
      end
      n_vec++;
    end
  endtask

  task automatic test_scan();
    int fs_seen;
    int last_change;
    logic [1:0] prev_sel;
    logic prev_fs;
    fs_seen = 0;
    last_change = -1;
    prev_sel = digit_sel;
    prev_fs = frame_start;
    for (int i = 0; i < 64; i++) begin
      step();
      if (dut_out() !== exp_out()) begin
        n_miss++;
        $display("FAIL scan_model cyc=%0d actual=%h required=%h", i, dut_out(), exp_out());
      end
      n_vec++;
      if (prev_fs === 1'b1) begin
        if ({prev_sel, digit_sel} !== {2'd3, 2'd0}) begin
          n_miss++;
          $display("FAIL scan_wrap actual=%0d->%0d required=3->0", prev_sel, digit_sel);
        end
        n_vec++;
      end
      if (digit_sel !== prev_sel) begin
        if (last_change >= 0 && (i - last_change) != 8) begin
          n_miss++;
          $display("FAIL scan_period actual=%0d required=8", i - last_change);
        end
        if (last_change >= 0) n_vec++;
        last_change = i;
      end
      if (frame_start === 1'b1) fs_seen++;
      prev_sel = digit_sel;
      prev_fs = frame_start;
    end
    if (fs_seen != 2) begin
      n_miss++;
      $display("FAIL scan_frame_count actual=%0d required=2", fs_seen);
    end
    n_vec++;
  endtask

  task automatic test_handshake();
    int i;
    goto(1, 3);
    digits_in = 16'h1234;
    upd_req = 1'b1;
    sbq.push_back(16'h1234);
    i = 0;
    while (sbq.size() != 0 && i < 40) begin
      step();
      if (dut_out() !== exp_out()) begin
        n_miss++;
        $display("FAIL hs_wait actual=%h required=%h", dut_out(), exp_out());
      end
      n_vec++;
      i++;
    end
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL hs_ack_timeout actual=none required=ack");
      sbq.delete();
    end
    n_vec++;
    upd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] sh;
      goto(k, 4);
      sh = cap >> (4 * k);
      if (nibble !== sh[3:0]) begin
        n_miss++;
        $display("FAIL hs_nibble slot=%0d actual=%h required=%h", k, nibble, sh[3:0]);
      end
      n_vec++;
    end
  endtask

  task automatic test_blanking();
    logic [3:0] want;
    for (int s = 1; s <= 3; s += 2) begin
      goto(s, 0);
      for (int c = 0; c < 8; c++) begin
        want = (c < 2) ? 4'hF : ((s == 1) ? 4'b1101 : 4'b0111);
        if (anode_n !== want) begin
          n_miss++;
          $display("FAIL blank slot=%0d cnt=%0d actual=%b required=%b", s, c, anode_n, want);
        end
        n_vec++;
        step();
      end
    end
  endtask

  task automatic test_coincident();
    goto(3, 7);
    digits_in = 16'hABCD;
    upd_req = 1'b1;
    sbq.push_back(16'hABCD);
    #1;
    if ({upd_ack, frame_start} !== 2'b11) begin
      n_miss++;
      $display("FAIL coincident_ack actual=%b required=11", {upd_ack, frame_start});
    end
    n_vec++;
    step();
    upd_req = 1'b0;
    if (nibble !== 4'hD || digit_sel !== 2'd0) begin
      n_miss++;
      $display("FAIL coincident_capture actual=%0d/%h required=0/d", digit_sel, nibble);
    end
    n_vec++;
    sbq.delete();
  endtask

  task automatic test_enable_stall();
    int n;
    goto(2, 3);
    en = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      if ({digit_sel, anode_n, frame_start, upd_ack} !== {2'd2, 4'hF, 2'b00}) begin
        n_miss++;
        $display("FAIL stall_hold actual=%0d/%b required=2/1111", digit_sel, anode_n);
      end
      n_vec++;
      step();
    end
    en = 1'b1;
    n = 0;
    while (digit_sel === 2'd2 && n < 20) begin
      step();
      n++;
    end
    if (n != 5) begin
      n_miss++;
      $display("FAIL stall_resume actual=%0d required=5", n);
    end
    n_vec++;
  endtask

  task automatic test_reset_pending();
    goto(0, 2);
    digits_in = 16'h5A5A;
    upd_req = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    #1;
    if (dut_out() !== RESET_OUT) begin
      n_miss++;
      $display("FAIL rst_pending_now actual=%h required=%h", dut_out(), RESET_OUT);
    end
    n_vec++;
    step(); step();
    if (dut_out() !== RESET_OUT) begin
      n_miss++;
      $display("FAIL rst_pending_hold actual=%h required=%h", dut_out(), RESET_OUT);
    end
    n_vec++;
    upd_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dut_out() !== exp_out()) begin
        n_miss++;
        $display("FAIL rst_restart actual=%h required=%h", dut_out(), exp_out());
      end
      n_vec++;
    end
  endtask

  task automatic test_leading_zero();
    int i;
    logic [3:0] want_an;
    logic [3:0] want_nib;
    goto(2, 0);
    digits_in = 16'h0030;
    upd_req = 1'b1;
    sbq.push_back(16'h0030);
    i = 0;
    while (sbq.size() != 0 && i < 40) begin
      step();
      i++;
    end
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL lz_ack_timeout actual=none required=ack");
      sbq.delete();
    end
    n_vec++;
    upd_req = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      goto((k == 3) ? 3 : k, 4);
      want_an = 4'hF;
      want_an[k] = 1'b0;
`ifdef SCAN_LEADING_ZERO_BLANK_EN
      if (k >= 2) want_an = 4'hF;
`endif
      want_nib = (k == 1) ? 4'h3 : 4'h0;
      if ({anode_n, nibble} !== {want_an, want_nib}) begin
        n_miss++;
        $display("FAIL lz_slot%0d actual=%b/%h required=%b/%h", k, anode_n, nibble, want_an, want_nib);
      end
      n_vec++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_blanking();
    test_coincident();
    test_enable_stall();
    test_reset_pending();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/display_scan_scheduler.md
DISPLAY_SCAN_SCHEDULER -- requirements
Module: display_scan_scheduler

Interface
REQ-001 The block SHALL have parameter DIV, default 50000: clk cycles per digit slot, legal range 2..65535.
REQ-002 The block SHALL have parameter BLANK, default 4: dead-time clk cycles at the start of each slot, legal range 0..DIV-1.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: scan enable.
REQ-006 The block SHALL have port digits_in, input, 16 bits: four nibbles, digit k = bits 4k+3..4k.
REQ-007 The block SHALL have port upd_req, input, 1 bit: request to load digits_in, held high until acknowledged.
REQ-008 The block SHALL have port upd_ack, output, 1 bit: one-cycle acknowledge of digits_in capture.
REQ-009 The block SHALL have port digit_sel, output, 2 bits: current slot index.
REQ-010 The block SHALL have port anode_n, output, 4 bits: active-low one-hot digit enable.
REQ-011 The block SHALL have port nibble, output, 4 bits: shadow nibble for the current slot.
REQ-012 The block SHALL have port frame_start, output, 1 bit: frame-boundary strobe.

Function
REQ-013 Prescaler SHALL count 0..DIV-1 while en=1, hold while en=0; tick = en && count==DIV-1, count wraps to 0 on tick.
REQ-014 digit_sel SHALL increment mod 4 on each tick edge (3->0 wrap); hold otherwise.
REQ-015 frame_start SHALL be combinational: tick && digit_sel==3, high exactly one cycle per frame.
REQ-016 upd_ack SHALL be combinational: frame_start && upd_req; shadow register SHALL capture digits_in on that edge.
REQ-017 upd_req rising in the same cycle as frame_start SHALL be acknowledged that cycle; otherwise ack waits for the next frame_start.
REQ-018 upd_req still high after ack SHALL cause a new capture at each subsequent frame_start; the requester must hold digits_in stable while upd_req=1.
REQ-019 While en=0, no tick, frame_start or upd_ack SHALL occur; pending requests stall.
REQ-020 nibble SHALL equal shadow[4*digit_sel+3 : 4*digit_sel] at all times.
REQ-021 anode_n SHALL be 4'hF when en=0 or count<BLANK, else bit digit_sel low, others high; BLANK=0 means no dead time.

Reset
REQ-022 rst=1 SHALL immediately force count=0, digit_sel=0, shadow=16'h0000, making nibble=0, anode_n=4'hF, upd_ack=0 and frame_start=0.
REQ-023 Reset mid-frame or mid-request SHALL discard the pending request without ack; scanning restarts from slot 0, count 0 on the first edge after rst falls.

Configuration
REQ-024 With macro SCAN_LEADING_ZERO_BLANK_EN defined, slot k (k=3,2,1) SHALL be blanked (anode_n=4'hF) when shadow digit k and every higher digit are zero; slot 0 SHALL never be blanked by this rule.
REQ-025 Without SCAN_LEADING_ZERO_BLANK_EN, all four slots SHALL be driven per REQ-021 regardless of value; no extra logic.

Verification (DIV=8, BLANK=2)
REQ-026 Scan: rst then en=1 -> digit_sel 0,1,2,3,0 on every 8th edge; frame_start high only in the cycle before the 3->0 wrap.
REQ-027 Blanking: after every tick, anode_n=4'hF for 2 cycles, then 4'b1101 during slot 1, 4'b0111 during slot 3.
REQ-028 Handshake: upd_req=1 with digits_in=16'h1234 mid-frame -> upd_ack only in the frame_start cycle; afterwards nibble=4,3,2,1 in slots 0..3.
REQ-029 Coincident: upd_req rising in the frame_start cycle -> upd_ack that same cycle.
REQ-030 en=0 for 5 cycles in slot 2 -> digit_sel, count held, anode_n=4'hF; with en=1, slot 2 completes its remaining cycles.
REQ-031 Reset/config: rst during pending upd_req -> no ack, all outputs at reset values; with macro, shadow=16'h0030 -> slots 3,2 blanked, slot 1 shows 3, slot 0 shows 0.
